// File: rtl/stopwatch_ctrl_if.sv
// ============================================================================
// Module      : stopwatch_ctrl_if
// Description : Bundle of the stopwatch button inputs and display outputs.
//               master modport : drives buttons, observes display (user side)
//               slave  modport : receives buttons, drives display (stopwatch)
//   btn_run / btn_clear / btn_mode / btn_lap : debounced button levels
//   msec[6:0] sec[6:0] min[6:0] hour[4:0]    : displayed time
//   sw_mode : 0 = msec/sec page, 1 = min/hour page
//   o_run   : high while running
//   o_lap   : high while a lap snapshot is displayed
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stopwatch_ctrl_if;
   logic       btn_run;
   logic       btn_clear;
   logic       btn_mode;
   logic       btn_lap;
   logic [6:0] msec;
   logic [6:0] sec;
   logic [6:0] min;
   logic [4:0] hour;
   logic       sw_mode;
   logic       o_run;
   logic       o_lap;

   modport master (
      output btn_run, btn_clear, btn_mode, btn_lap,
      input  msec, sec, min, hour, sw_mode, o_run, o_lap
   );

   modport slave (
      input  btn_run, btn_clear, btn_mode, btn_lap,
      output msec, sec, min, hour, sw_mode, o_run, o_lap
   );
endinterface

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Stopwatch controller with STOP/RUN/CLEAR state machine, a
//               TICK_DIV clock divider producing a 10 ms tick and cascaded
//               hundredths/seconds/minutes/hours counters.
//   clk   : system clock, all state updates on rising edge
//   reset : synchronous active-high reset
//   bus   : stopwatch_ctrl_if.slave (buttons in, display out)
// Optional feature macro : STOPWATCH_LAP_EN (lap snapshot display)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_ctrl #(
   parameter int TICK_DIV = 1_000_000
) (
   input  logic             clk,
   input  logic             reset,
   stopwatch_ctrl_if.slave  bus
);

   localparam int                 c_div_w   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [c_div_w-1:0] c_div_max = c_div_w'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [c_div_w-1:0] div_q, div_d;
   logic [6:0]         msec_q, msec_d;
   logic [6:0]         sec_q, sec_d;
   logic [6:0]         min_q, min_d;
   logic [4:0]         hour_q, hour_d;
   logic               mode_q, mode_d;
   logic               run_q, run_d;
   logic               run_prev_q, run_prev_d;
   logic               clear_prev_q, clear_prev_d;
   logic               mode_prev_q, mode_prev_d;
   logic               w_run_rise, w_clear_rise, w_mode_rise, w_tick;

   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      msec_d       = msec_q;
      sec_d        = sec_q;
      min_d        = min_q;
      hour_d       = hour_q;
      mode_d       = mode_q;
      w_tick       = 1'b0;
      run_prev_d   = bus.btn_run;
      clear_prev_d = bus.btn_clear;
      mode_prev_d  = bus.btn_mode;
      w_run_rise   = bus.btn_run   & ~run_prev_q;
      w_clear_rise = bus.btn_clear & ~clear_prev_q;
      w_mode_rise  = bus.btn_mode  & ~mode_prev_q;

      // Display page select is independent of the run state and of CLEAR.
      if (w_mode_rise) begin
         mode_d = ~mode_q;
      end

      case (state_q)
         ST_STOP: begin
            // Clear has priority over run when both rise together.
            if (w_clear_rise) begin
               state_d = ST_CLEAR;
            end else if (w_run_rise) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (div_q == c_div_max) begin
               div_d  = '0;
               w_tick = 1'b1;
            end else begin
               div_d = div_q + 1'b1;
            end
            if (w_run_rise) begin
               state_d = ST_STOP;
            end
         end
         ST_CLEAR: begin
            div_d   = '0;
            msec_d  = '0;
            sec_d   = '0;
            min_d   = '0;
            hour_d  = '0;
            state_d = ST_STOP;
         end
         default: begin
            state_d = ST_STOP;
         end
      endcase

      // Full carry chain resolves within the tick cycle.
      if (w_tick) begin
         if (msec_q == 7'd99) begin
            msec_d = '0;
            if (sec_q == 7'd59) begin
               sec_d = '0;
               if (min_q == 7'd59) begin
                  min_d  = '0;
                  hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
               end else begin
                  min_d = min_q + 7'd1;
               end
            end else begin
               sec_d = sec_q + 7'd1;
            end
         end else begin
            msec_d = msec_q + 7'd1;
         end
      end

      run_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_STOP;
         div_q        <= '0;
         msec_q       <= '0;
         sec_q        <= '0;
         min_q        <= '0;
         hour_q       <= '0;
         mode_q       <= 1'b0;
         run_q        <= 1'b0;
         // Prev flops start high so a button held through reset is not an edge.
         run_prev_q   <= 1'b1;
         clear_prev_q <= 1'b1;
         mode_prev_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         msec_q       <= msec_d;
         sec_q        <= sec_d;
         min_q        <= min_d;
         hour_q       <= hour_d;
         mode_q       <= mode_d;
         run_q        <= run_d;
         run_prev_q   <= run_prev_d;
         clear_prev_q <= clear_prev_d;
         mode_prev_q  <= mode_prev_d;
      end
   end

   assign bus.sw_mode = mode_q;
   assign bus.o_run   = run_q;

`ifdef STOPWATCH_LAP_EN
   logic       lap_q, lap_d;
   logic       lap_prev_q, lap_prev_d;
   logic       w_lap_rise;
   logic [6:0] snap_msec_q, snap_msec_d;
   logic [6:0] snap_sec_q, snap_sec_d;
   logic [6:0] snap_min_q, snap_min_d;
   logic [4:0] snap_hour_q, snap_hour_d;

   always_comb begin
      lap_prev_d  = bus.btn_lap;
      w_lap_rise  = bus.btn_lap & ~lap_prev_q;
      lap_d       = lap_q;
      snap_msec_d = snap_msec_q;
      snap_sec_d  = snap_sec_q;
      snap_min_d  = snap_min_q;
      snap_hour_d = snap_hour_q;
      case (state_q)
         ST_RUN: begin
            if (w_lap_rise) begin
               lap_d = ~lap_q;
               // Capture the time currently shown when the lap view opens.
               if (!lap_q) begin
                  snap_msec_d = msec_q;
                  snap_sec_d  = sec_q;
                  snap_min_d  = min_q;
                  snap_hour_d = hour_q;
               end
            end
         end
         ST_STOP: begin
            if (w_lap_rise) begin
               lap_d = 1'b0;
            end
         end
         ST_CLEAR: begin
            lap_d = 1'b0;
         end
         default: begin
            lap_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lap_q       <= 1'b0;
         lap_prev_q  <= 1'b1;
         snap_msec_q <= '0;
         snap_sec_q  <= '0;
         snap_min_q  <= '0;
         snap_hour_q <= '0;
      end else begin
         lap_q       <= lap_d;
         lap_prev_q  <= lap_prev_d;
         snap_msec_q <= snap_msec_d;
         snap_sec_q  <= snap_sec_d;
         snap_min_q  <= snap_min_d;
         snap_hour_q <= snap_hour_d;
      end
   end

   assign bus.o_lap = lap_q;
   assign bus.msec  = lap_q ? snap_msec_q : msec_q;
   assign bus.sec   = lap_q ? snap_sec_q  : sec_q;
   assign bus.min   = lap_q ? snap_min_q  : min_q;
   assign bus.hour  = lap_q ? snap_hour_q : hour_q;
`else
   logic w_unused_lap;
   assign w_unused_lap = bus.btn_lap;

   assign bus.o_lap = 1'b0;
   assign bus.msec  = msec_q;
   assign bus.sec   = sec_q;
   assign bus.min   = min_q;
   assign bus.hour  = hour_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Directed self-checking bench for stopwatch_ctrl (TICK_DIV=4).
//               Inputs change and outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   stopwatch_ctrl_if bus ();

   stopwatch_ctrl #(.TICK_DIV(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic preload_max();
      force dut.msec_q = 7'd99;
      force dut.sec_q  = 7'd59;
      force dut.min_q  = 7'd59;
      force dut.hour_q = 5'd23;
      #1;
      release dut.msec_q;
      release dut.sec_q;
      release dut.min_q;
      release dut.hour_q;
   endtask

   initial begin
      reset         = 1'b1;
      bus.btn_run   = 1'b1;   // held through reset
      bus.btn_clear = 1'b0;
      bus.btn_mode  = 1'b0;
      bus.btn_lap   = 1'b0;
      step(3);
      check("rst_msec", bus.msec, 0);
      check("rst_hour", bus.hour, 0);
      check("rst_run", bus.o_run, 0);
      check("rst_mode", bus.sw_mode, 0);
      check("rst_lap", bus.o_lap, 0);

      reset = 1'b0;
      step(3);
      check("held_run_no_edge", bus.o_run, 0);

      // Run rise -> RUN next edge, first tick 4 cycles later.
      bus.btn_run = 1'b0;
      step(1);
      bus.btn_run = 1'b1;
      step(1);
      check("run_on", bus.o_run, 1);
      check("run_msec0", bus.msec, 0);
      bus.btn_run = 1'b0;
      step(3);
      check("pre_tick_msec", bus.msec, 0);
      step(1);
      check("first_tick_msec", bus.msec, 1);
      step(96);
      check("msec_25", bus.msec, 25);

      // Stop with divider left at 2, then resume: tick after 2 cycles.
      step(1);
      bus.btn_run = 1'b1;
      step(1);
      check("stop_run", bus.o_run, 0);
      bus.btn_run = 1'b0;
      step(3);
      check("stop_hold_msec", bus.msec, 25);
      bus.btn_run = 1'b1;
      step(1);
      check("resume_run", bus.o_run, 1);
      bus.btn_run = 1'b0;
      step(1);
      check("resume_1_msec", bus.msec, 25);
      step(1);
      check("resume_2_msec", bus.msec, 26);

      // Clear rise in RUN is ignored.
      bus.btn_clear = 1'b1;
      step(1);
      check("clr_in_run_run", bus.o_run, 1);
      check("clr_in_run_msec", bus.msec, 26);
      bus.btn_clear = 1'b0;
      step(3);
      check("clr_in_run_tick", bus.msec, 27);
      bus.btn_run = 1'b1;
      step(1);
      check("stop2_run", bus.o_run, 0);
      bus.btn_run = 1'b0;
      step(1);

      // Full wrap 23:59:59.99 -> 00:00:00.00, run rise on the tick edge.
      // Divider is 1 here, so the tick lands on the third edge in RUN.
      preload_max();
      step(1);
      bus.btn_run = 1'b1;
      step(1);
      bus.btn_run = 1'b0;
      step(2);
      check("pre_wrap_hour", bus.hour, 23);
      check("pre_wrap_min", bus.min, 59);
      check("pre_wrap_sec", bus.sec, 59);
      check("pre_wrap_msec", bus.msec, 99);
      bus.btn_run = 1'b1;
      step(1);
      check("wrap_hour", bus.hour, 0);
      check("wrap_min", bus.min, 0);
      check("wrap_sec", bus.sec, 0);
      check("wrap_msec", bus.msec, 0);
      check("wrap_run_off", bus.o_run, 0);
      bus.btn_run = 1'b0;
      step(1);

      // In STOP, run and clear rise together: clear wins.
      preload_max();
      step(1);
      bus.btn_run   = 1'b1;
      bus.btn_clear = 1'b1;
      step(1);
      check("clr_enter_run", bus.o_run, 0);
      step(1);
      check("clr_hour", bus.hour, 0);
      check("clr_min", bus.min, 0);
      check("clr_sec", bus.sec, 0);
      check("clr_msec", bus.msec, 0);
      check("clr_run", bus.o_run, 0);
      bus.btn_run   = 1'b0;
      bus.btn_clear = 1'b0;
      step(5);
      check("clr_stays_stop", bus.o_run, 0);
      check("clr_stays_zero", bus.msec, 0);

      // Mode toggles.
      bus.btn_mode = 1'b1;
      step(1);
      check("mode_1", bus.sw_mode, 1);
      bus.btn_mode = 1'b0;
      step(1);
      bus.btn_mode = 1'b1;
      step(1);
      check("mode_0", bus.sw_mode, 0);
      bus.btn_mode = 1'b0;

      // Lap: freeze at 10 while counting to 30, then release to live.
      bus.btn_run = 1'b1;
      step(1);
      bus.btn_run = 1'b0;
      step(40);
      check("lap_pre_msec", bus.msec, 10);
      bus.btn_lap = 1'b1;
      step(1);
`ifdef STOPWATCH_LAP_EN
      check("lap_on", bus.o_lap, 1);
`else
      check("lap_off_build", bus.o_lap, 0);
`endif
      check("lap_on_msec", bus.msec, 10);
      bus.btn_lap = 1'b0;
      step(79);
`ifdef STOPWATCH_LAP_EN
      check("lap_frozen_msec", bus.msec, 10);
`else
      check("live_msec", bus.msec, 30);
`endif
      bus.btn_lap = 1'b1;
      step(1);
      check("lap_release_msec", bus.msec, 30);
      check("lap_release_flag", bus.o_lap, 0);
      bus.btn_lap = 1'b0;

      // Reset mid-RUN overrides a simultaneous mode rise.
      bus.btn_mode = 1'b1;
      reset        = 1'b1;
      step(1);
      check("midrun_rst_run", bus.o_run, 0);
      check("midrun_rst_msec", bus.msec, 0);
      check("midrun_rst_mode", bus.sw_mode, 0);
      reset = 1'b0;
      step(2);
      check("held_mode_no_edge", bus.sw_mode, 0);
      bus.btn_mode = 1'b0;
      step(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1_000_000, giving clk cycles per 10 ms tick (100 MHz clk).
REQ-002 The block SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port btn_run, input, 1, debounced level; a rising edge toggles run/stop.
REQ-005 The block SHALL have port btn_clear, input, 1, debounced level; a rising edge requests a clear.
REQ-006 The block SHALL have port btn_mode, input, 1, debounced level; a rising edge toggles display mode.
REQ-007 The block SHALL have port btn_lap, input, 1, debounced level; lap control, used only when LAP_EN is defined.
REQ-008 The block SHALL have port msec, output, 7, hundredths of a second, 0..99.
REQ-009 The block SHALL have port sec, output, 7, seconds, 0..59.
REQ-010 The block SHALL have port min, output, 7, minutes, 0..59.
REQ-011 The block SHALL have port hour, output, 5, hours, 0..23.
REQ-012 The block SHALL have port sw_mode, output, 1, display select: 0 = msec/sec, 1 = min/hour.
REQ-013 The block SHALL have port o_run, output, 1, high while in state RUN.
REQ-014 The block SHALL have port o_lap, output, 1, high while a lap snapshot is displayed.

Function
REQ-015 Each btn_* SHALL have a registered previous-value flop; rise = btn & ~prev; all prev flops reset to 1, so a button held through reset produces no event.
REQ-016 The FSM SHALL have states STOP, RUN and CLEAR; every output SHALL be registered, so a rise sampled at edge k is visible after edge k.
REQ-017 In STOP: a run rise SHALL go to RUN; a clear rise SHALL go to CLEAR; if both rise together, clear SHALL win.
REQ-018 In RUN: a run rise SHALL go to STOP; a clear rise SHALL be ignored.
REQ-019 CLEAR SHALL last exactly one cycle, zero the tick divider and all time counters, then go to STOP.
REQ-020 The tick divider SHALL count only in RUN and hold its value in STOP, so resume keeps the sub-tick fraction.
REQ-021 The tick SHALL be a one-cycle pulse when divider == TICK_DIV-1, and the divider SHALL wrap to 0 on that cycle.
REQ-022 On a tick, the counters SHALL cascade in the same cycle: msec 99→0 carries to sec; sec 59→0 carries to min; min 59→0 carries to hour; hour 23→0 wraps with no carry out.
REQ-023 A run rise on the same cycle as a tick SHALL apply the tick increment and leave RUN.
REQ-024 sw_mode SHALL toggle on a btn_mode rise in any state and SHALL not be affected by CLEAR.
REQ-025 Time outputs SHALL never show out-of-range values.

Reset
REQ-026 On reset, state SHALL be STOP; the divider, msec, sec, min, hour, sw_mode, o_run, o_lap and lap snapshot SHALL be 0; prev flops SHALL be 1.
REQ-027 Reset SHALL override all button events on the same edge, including mid-RUN and during CLEAR.

Configuration
REQ-028 With macro STOPWATCH_LAP_EN defined, a btn_lap rise in RUN SHALL toggle o_lap.
REQ-029 With STOPWATCH_LAP_EN defined, the transition to o_lap = 1 SHALL capture the live counters in a snapshot, and the time outputs SHALL show the snapshot while counting continues internally.
REQ-030 With STOPWATCH_LAP_EN defined, a btn_lap rise in STOP SHALL clear o_lap, and CLEAR SHALL clear o_lap.
REQ-031 Without STOPWATCH_LAP_EN, btn_lap SHALL be ignored, o_lap SHALL be constant 0, no snapshot registers SHALL be built, and the time outputs SHALL always be live.

Verification
REQ-032 The bench SHALL cover reset then run rise with TICK_DIV=4 → o_run=1 next cycle; msec=1 after 4 cycles; msec=25 after 100 cycles.
REQ-033 The bench SHALL cover preloaded 23:59:59.99 with RUN and one tick → hour=0, min=0, sec=0, msec=0 on the same edge.
REQ-034 The bench SHALL cover run, stop at divider=2, resume → next tick 2 cycles after resume, not 4.
REQ-035 The bench SHALL cover, in STOP, btn_run and btn_clear rising together → CLEAR for 1 cycle, all counters 0, o_run=0; a clear rise in RUN → counting unaffected.
REQ-036 The bench SHALL cover btn_run held high through reset release → no transition; btn_mode rise twice → sw_mode 1 then 0.
REQ-037 The bench SHALL cover, with STOPWATCH_LAP_EN, a lap rise at msec=10 → outputs frozen at 10 while internal msec reaches 30; second lap rise → outputs show live value on the next cycle.
